// File: rtl/instr_pkg.sv
// Shared definitions for the MIPS instruction encoder and the control decoder.
// Holds the mnemonic enum, standard opcode/funct values, FSM state type and
// field-packing helpers used to build R/I/J words.
package instr_pkg;

  // Primary opcodes (instruction bits 31:26)
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (instruction bits 5:0)
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  // Symbolic mnemonic ids; any 6-bit value past M_JAL is illegal
  typedef enum logic [5:0] {
    M_ADD = 6'd0, M_ADDU, M_SUB, M_SUBU, M_AND, M_OR, M_XOR, M_NOR,
    M_SLT, M_SLTU, M_SLL, M_SRL, M_SRA, M_SLLV, M_SRLV, M_SRAV,
    M_JR, M_JALR, M_ADDI, M_SLTI, M_ANDI, M_ORI, M_LUI,
    M_LW, M_LB, M_LH, M_LBU, M_LHU, M_SW, M_SB, M_SH,
    M_BEQ, M_BNE, M_J, M_JAL
  } mnem_e;

  // Loader FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
    return {OP_RTYPE, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_word(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Packs a symbolic mnemonic plus fields into a 32-bit MIPS word.
// Purely combinational; zero latency.
// No flow control; unknown ids raise illegal and yield a zero word.
module instr_pack
  import instr_pkg::*;
(
  input  logic [5:0]  mnem,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  // Select layout and forced-zero fields per mnemonic
  always_comb begin
    word    = 32'h0;
    illegal = 1'b0;
    case (mnem)
      M_ADD:  word = r_word(rs, rt, rd, 5'd0, FN_ADD);
      M_ADDU: word = r_word(rs, rt, rd, 5'd0, FN_ADDU);
      M_SUB:  word = r_word(rs, rt, rd, 5'd0, FN_SUB);
      M_SUBU: word = r_word(rs, rt, rd, 5'd0, FN_SUBU);
      M_AND:  word = r_word(rs, rt, rd, 5'd0, FN_AND);
      M_OR:   word = r_word(rs, rt, rd, 5'd0, FN_OR);
      M_XOR:  word = r_word(rs, rt, rd, 5'd0, FN_XOR);
      M_NOR:  word = r_word(rs, rt, rd, 5'd0, FN_NOR);
      M_SLT:  word = r_word(rs, rt, rd, 5'd0, FN_SLT);
      M_SLTU: word = r_word(rs, rt, rd, 5'd0, FN_SLTU);
      // constant shifts take the amount from shamt and have no rs operand
      M_SLL:  word = r_word(5'd0, rt, rd, shamt, FN_SLL);
      M_SRL:  word = r_word(5'd0, rt, rd, shamt, FN_SRL);
      M_SRA:  word = r_word(5'd0, rt, rd, shamt, FN_SRA);
      M_SLLV: word = r_word(rs, rt, rd, 5'd0, FN_SLLV);
      M_SRLV: word = r_word(rs, rt, rd, 5'd0, FN_SRLV);
      M_SRAV: word = r_word(rs, rt, rd, 5'd0, FN_SRAV);
      M_JR:   word = r_word(rs, 5'd0, 5'd0, 5'd0, FN_JR);
      // rd is passed through as given; rd=0 is not promoted to $31
      M_JALR: word = r_word(rs, 5'd0, rd, 5'd0, FN_JALR);
      M_ADDI: word = i_word(OP_ADDI, rs, rt, imm);
      M_SLTI: word = i_word(OP_SLTI, rs, rt, imm);
      M_ANDI: word = i_word(OP_ANDI, rs, rt, imm);
      M_ORI:  word = i_word(OP_ORI, rs, rt, imm);
      M_LUI:  word = i_word(OP_LUI, 5'd0, rt, imm);
      M_LW:   word = i_word(OP_LW, rs, rt, imm);
      M_LB:   word = i_word(OP_LB, rs, rt, imm);
      M_LH:   word = i_word(OP_LH, rs, rt, imm);
      M_LBU:  word = i_word(OP_LBU, rs, rt, imm);
      M_LHU:  word = i_word(OP_LHU, rs, rt, imm);
      M_SW:   word = i_word(OP_SW, rs, rt, imm);
      M_SB:   word = i_word(OP_SB, rs, rt, imm);
      M_SH:   word = i_word(OP_SH, rs, rt, imm);
      M_BEQ:  word = i_word(OP_BEQ, rs, rt, imm);
      M_BNE:  word = i_word(OP_BNE, rs, rt, imm);
      M_J:    word = j_word(OP_J, target);
      M_JAL:  word = j_word(OP_JAL, target);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: encodes symbolic instructions and writes them to consecutive IM words.
// Latency: accepted instruction is presented on imem_* the cycle after acceptance.
// Backpressure: 2-entry buffer; in_ready drops when full, imem outputs hold while imem_ready=0.
module instr_encoder
  import instr_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [5:0]        in_mnem,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       word_count
);

  state_e            state, state_nxt;
  logic [31:0]       buf_mem [2];
  logic              buf_wp, buf_rp;
  logic [1:0]        occ;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       cnt_q;
  logic              err_q;
  logic [31:0]       pack_word;
  logic              pack_illegal;
  logic              accept, push, pop, start_ok;

  instr_pack u_pack (
    .mnem    (in_mnem),
    .rs      (in_rs),
    .rt      (in_rt),
    .rd      (in_rd),
    .shamt   (in_shamt),
    .imm     (in_imm),
    .target  (in_target),
    .word    (pack_word),
    .illegal (pack_illegal)
  );

  // Illegal ids complete the handshake but never enter the buffer
  assign in_ready   = (state == ST_LOAD) && (occ != 2'd2);
  assign accept     = in_valid && in_ready;
  assign push       = accept && !pack_illegal;
  assign pop        = imem_we && imem_ready;
  assign start_ok   = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign imem_we    = (occ != 2'd0);
  assign imem_wdata = imem_we ? buf_mem[buf_rp] : 32'h0;
  assign imem_addr  = addr_q;
  assign err        = err_q;
  assign word_count = cnt_q;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and status outputs
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        busy = 1'b1;
        if (accept && in_last) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        // leave once the last buffered word is popped (or nothing was buffered)
        if ((occ == 2'd0) || ((occ == 2'd1) && pop)) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = start ? ST_LOAD : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Two-entry word buffer; the head drives imem_wdata
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      buf_mem[0] <= 32'h0;
      buf_mem[1] <= 32'h0;
      buf_wp     <= 1'b0;
      buf_rp     <= 1'b0;
      occ        <= 2'd0;
    end else begin
      if (push) begin
        buf_mem[buf_wp] <= pack_word;
        buf_wp          <= ~buf_wp;
      end
      if (pop) buf_rp <= ~buf_rp;
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Write address of the buffer head, written-word count and sticky error
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q <= '0;
      cnt_q  <= 16'h0;
      err_q  <= 1'b0;
    end else if (start_ok) begin
      addr_q <= {base_addr[ADDR_W-1:2], 2'b00};
      cnt_q  <= 16'h0;
      err_q  <= 1'b0;
    end else begin
      if (pop) begin
        addr_q <= addr_q + ADDR_W'(4);
        if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'h1;
      end
      if (accept && pack_illegal) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed program scenarios plus
// randomized programs, compared every cycle against a queue-based model.
module tb_instr_encoder;
  import instr_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = 32'h0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_last = 1'b0;
  logic [5:0]  in_mnem = 6'h0;
  logic [4:0]  in_rs = 5'h0, in_rt = 5'h0, in_rd = 5'h0, in_shamt = 5'h0;
  logic [15:0] in_imm = 16'h0;
  logic [25:0] in_target = 26'h0;
  logic        imem_we;
  logic        imem_ready = 1'b1;
  logic [31:0] imem_addr, imem_wdata;
  logic        busy, done, err;
  logic [15:0] word_count;

  instr_encoder #(.ADDR_W(32)) dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_imm(in_imm), .in_target(in_target),
    .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .busy(busy), .done(done), .err(err),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference encoder: table of (format, opcode, funct, which fields survive)
  function automatic logic [32:0] ref_enc(input logic [5:0] m, input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
      input logic [15:0] imm, input logic [25:0] tg);
    int fmt;
    logic [5:0] op, fn;
    bit k_rs, k_rt, k_rd, k_sh;
    logic [31:0] w;
    fmt = 0; op = 6'h0; fn = 6'h0; k_rs = 1; k_rt = 1; k_rd = 1; k_sh = 0; w = 32'h0;
    case (m)
      M_ADD: fn = 6'h20;  M_ADDU: fn = 6'h21;  M_SUB: fn = 6'h22;  M_SUBU: fn = 6'h23;
      M_AND: fn = 6'h24;  M_OR:   fn = 6'h25;  M_XOR: fn = 6'h26;  M_NOR:  fn = 6'h27;
      M_SLT: fn = 6'h2A;  M_SLTU: fn = 6'h2B;
      M_SLL: begin fn = 6'h00; k_rs = 0; k_sh = 1; end
      M_SRL: begin fn = 6'h02; k_rs = 0; k_sh = 1; end
      M_SRA: begin fn = 6'h03; k_rs = 0; k_sh = 1; end
      M_SLLV: fn = 6'h04; M_SRLV: fn = 6'h06; M_SRAV: fn = 6'h07;
      M_JR:   begin fn = 6'h08; k_rt = 0; k_rd = 0; end
      M_JALR: begin fn = 6'h09; k_rt = 0; end
      M_ADDI: begin fmt = 1; op = 6'h08; end
      M_SLTI: begin fmt = 1; op = 6'h0A; end
      M_ANDI: begin fmt = 1; op = 6'h0C; end
      M_ORI:  begin fmt = 1; op = 6'h0D; end
      M_LUI:  begin fmt = 1; op = 6'h0F; k_rs = 0; end
      M_LW:   begin fmt = 1; op = 6'h23; end
      M_LB:   begin fmt = 1; op = 6'h20; end
      M_LH:   begin fmt = 1; op = 6'h21; end
      M_LBU:  begin fmt = 1; op = 6'h24; end
      M_LHU:  begin fmt = 1; op = 6'h25; end
      M_SW:   begin fmt = 1; op = 6'h2B; end
      M_SB:   begin fmt = 1; op = 6'h28; end
      M_SH:   begin fmt = 1; op = 6'h29; end
      M_BEQ:  begin fmt = 1; op = 6'h04; end
      M_BNE:  begin fmt = 1; op = 6'h05; end
      M_J:    begin fmt = 2; op = 6'h02; end
      M_JAL:  begin fmt = 2; op = 6'h03; end
      default: fmt = -1;
    endcase
    if (fmt == 0)
      w = {6'h0, k_rs ? rs : 5'd0, k_rt ? rt : 5'd0, k_rd ? rd : 5'd0, k_sh ? sh : 5'd0, fn};
    else if (fmt == 1)
      w = {op, k_rs ? rs : 5'd0, rt, imm};
    else if (fmt == 2)
      w = {op, tg};
    return {(fmt < 0), w};
  endfunction

  // Behavioural model: queue of pending writes plus program-phase flags
  typedef struct packed { logic [31:0] a; logic [31:0] w; } wr_t;
  wr_t         mq[$];
  wr_t         wlog[$];
  int          wcyc[$];
  bit          m_load, m_drain, m_done, m_err;
  int          m_cnt;
  logic [31:0] m_next;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          done_cyc = 0;
  bit          e_acc, e_pop, e_start, e_drain_done;
  logic [32:0] e_enc;
  int          rdy_mode = 0;

  // Compare DUT against the model every cycle, then advance the model
  always @(negedge clk) begin
    if (!rstn) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_imem_we", imem_we, 0);
      chk("rst_imem_addr", imem_addr, 0);
      chk("rst_imem_wdata", imem_wdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_word_count", word_count, 0);
      mq.delete();
      m_load = 0; m_drain = 0; m_done = 0; m_err = 0; m_cnt = 0; m_next = 32'h0;
    end else begin
      chk("in_ready", in_ready, m_load && (mq.size() < 2));
      chk("imem_we", imem_we, mq.size() != 0);
      if (mq.size() != 0) begin
        chk("imem_addr", imem_addr, mq[0].a);
        chk("imem_wdata", imem_wdata, mq[0].w);
      end
      chk("busy", busy, m_load || m_drain);
      chk("done", done, m_done);
      chk("err", err, m_err);
      chk("word_count", word_count, 64'(m_cnt));
      if (done) done_cyc = cyc;

      e_start = start && !m_load && !m_drain;
      e_acc   = in_valid && m_load && (mq.size() < 2);
      e_pop   = (mq.size() != 0) && imem_ready;
      if (e_pop) begin
        wlog.push_back('{a: imem_addr, w: imem_wdata});
        wcyc.push_back(cyc);
        void'(mq.pop_front());
        if (m_cnt < 65535) m_cnt++;
      end
      if (e_acc) begin
        acc_cyc = cyc;
        e_enc = ref_enc(in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target);
        if (e_enc[32]) m_err = 1;
        else begin
          mq.push_back('{a: m_next, w: e_enc[31:0]});
          m_next = m_next + 32'd4;
        end
      end
      e_drain_done = m_drain && (mq.size() == 0);
      if (e_drain_done) m_drain = 0;
      if (e_acc && in_last) begin m_load = 0; m_drain = 1; end
      m_done = e_drain_done;
      if (e_start) begin
        m_load = 1; m_err = 0; m_cnt = 0; m_next = {base_addr[31:2], 2'b00};
      end
    end
    cyc++;
  end

  // Memory-side ready: always, random, or stalled
  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0:       imem_ready = 1'b1;
      1:       imem_ready = ($urandom_range(0, 3) != 0);
      default: imem_ready = 1'b0;
    endcase
  end

  int gap = 0;
  bit rnd_start = 0;

  task automatic do_start(input logic [31:0] b);
    base_addr = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [5:0] m, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                      input logic [25:0] tg, input bit last);
    int n;
    if (gap > 0) repeat ($urandom_range(0, gap)) begin @(posedge clk); #1; end
    in_valid = 1'b1; in_mnem = m; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
    in_imm = imm; in_target = tg; in_last = last;
    if (rnd_start && ($urandom_range(0, 5) == 0)) begin start = 1'b1; base_addr = $urandom; end
    n = 0;
    do begin @(negedge clk); n++; end while (!in_ready && n < 300);
    chk("send_accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 300);
    chk("done_seen", done, 1);
    @(posedge clk); #1;
  endtask

  task automatic chk_w(input string name, input int idx, input logic [31:0] a, input logic [31:0] w);
    if (idx < wlog.size()) begin
      chk({name, "_addr"}, wlog[idx].a, a);
      chk({name, "_data"}, wlog[idx].w, w);
    end else chk({name, "_missing"}, wlog.size(), idx + 1);
  endtask

  int b0;
  int len;

  initial begin
    // the reference encoder itself, pinned by hand-assembled words
    chk("ref_addi", ref_enc(M_ADDI, 0, 8, 0, 0, 16'd5, 0), {1'b0, 32'h20080005});
    chk("ref_jalr_rd0", ref_enc(M_JALR, 5, 7, 0, 3, 0, 0), {1'b0, 32'h00A00009});
    chk("ref_illegal", ref_enc(6'd63, 0, 0, 0, 0, 0, 0), {1'b1, 32'h0});

    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;

    // single addi program
    b0 = wlog.size();
    do_start(32'h00003000);
    send(M_ADDI, 0, 8, 0, 0, 16'd5, 0, 1);
    wait_done();
    chk_w("addi", b0, 32'h3000, 32'h20080005);
    chk("addi_done_lat", done_cyc - acc_cyc, 2);
    chk("addi_count", word_count, 1);

    // back-to-back stream, forced-zero fields given garbage
    b0 = wlog.size();
    do_start(32'h00000103);
    send(M_ADD, 1, 2, 3, 7, 0, 0, 0);
    send(M_SLL, 9, 5, 4, 2, 0, 0, 0);
    send(M_JR, 31, 4, 6, 1, 0, 0, 0);
    send(M_LUI, 7, 9, 3, 0, 16'h1234, 0, 1);
    wait_done();
    chk_w("add", b0, 32'h100, 32'h00221820);
    chk_w("sll", b0 + 1, 32'h104, 32'h00052080);
    chk_w("jr", b0 + 2, 32'h108, 32'h03E00008);
    chk_w("lui", b0 + 3, 32'h10C, 32'h3C091234);
    if (wcyc.size() >= b0 + 4) chk("stream_rate", wcyc[b0 + 3] - wcyc[b0], 3);
    chk("stream_count", word_count, 4);

    // memory stalled for the first cycles of a 4-word program
    b0 = wlog.size();
    rdy_mode = 2;
    do_start(32'h00000200);
    fork begin repeat (5) @(posedge clk); rdy_mode = 0; end join_none
    send(M_BEQ, 1, 2, 0, 0, 16'hFFFF, 0, 0);
    send(M_J, 0, 0, 0, 0, 0, 26'h0100000, 0);
    send(M_SW, 29, 4, 0, 0, 16'd8, 0, 0);
    send(M_ORI, 5, 5, 0, 0, 16'hABCD, 0, 1);
    wait_done();
    chk("stall_writes", wlog.size() - b0, 4);
    chk_w("beq", b0, 32'h200, 32'h1022FFFF);
    chk_w("j", b0 + 1, 32'h204, 32'h08100000);
    chk_w("sw", b0 + 2, 32'h208, 32'hAFA40008);
    chk_w("ori", b0 + 3, 32'h20C, 32'h34A5ABCD);

    // illegal id between two legal words
    b0 = wlog.size();
    do_start(32'h00000400);
    send(M_ADDI, 0, 8, 0, 0, 16'd5, 0, 0);
    send(6'd63, 1, 2, 3, 4, 16'h5555, 0, 0);
    send(M_ORI, 5, 5, 0, 0, 16'hABCD, 0, 1);
    wait_done();
    chk("illegal_err", err, 1);
    chk("illegal_writes", wlog.size() - b0, 2);
    chk_w("illegal_w0", b0, 32'h400, 32'h20080005);
    chk_w("illegal_w1", b0 + 1, 32'h404, 32'h34A5ABCD);
    do_start(32'h00000500);
    chk("start_clears_err", err, 0);
    send(6'd40, 0, 0, 0, 0, 0, 0, 1);
    wait_done();
    chk("illegal_last_err", err, 1);

    // reset with two words buffered
    b0 = wlog.size();
    rdy_mode = 2;
    do_start(32'h00000600);
    send(M_ADD, 1, 2, 3, 0, 0, 0, 0);
    send(M_SUB, 4, 5, 6, 0, 0, 0, 0);
    rstn = 1'b0;
    @(negedge clk);
    chk("midrst_we", imem_we, 0);
    chk("midrst_busy", busy, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    rdy_mode = 0;
    repeat (6) @(posedge clk);
    #1;
    chk("midrst_no_writes", wlog.size() - b0, 0);

    // randomized programs with random stalls, gaps, wrap-around and stray starts
    rdy_mode = 1;
    gap = 2;
    for (int p = 0; p < 30; p++) begin
      do_start((p == 3) ? 32'hFFFFFFF6 : $urandom);
      rnd_start = 1;
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++)
        send(6'($urandom_range(0, 40)), 5'($urandom), 5'($urandom), 5'($urandom),
             5'($urandom), 16'($urandom), 26'($urandom), i == len - 1);
      rnd_start = 0;
      wait_done();
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
